slice_interleaver: RTL
======================

// Module: slice_interleaver
// PURPOSE
//  Single-clock, parametrised successor of the decoder slice output mux. It buffers the pixel beats of
//  up to NBR_SLICES parallel slice decoders in per-slice FIFOs with valid/ready backpressure. It then
//  interleaves one chunk (one slice line) per slice, round-robin, into a raster pixel stream.
//  It sits between the slice decoders and the display/output formatter; out_ready backpressure replaces rate pacing.
// PARAMETERS
//  NBR_SLICES      4     number of slice input channels (>=1)
//  PIXS_PER_BEAT   4     pixels per beat (power of 2, 1..16)
//  NBR_COMP        3     components per pixel
//  BPC             14    bits per component
//  FIFO_DEPTH      64    beats per slice FIFO (power of 2, >=4)
//  MAX_SLICE_WIDTH 2560  max slice width in pixels; sets counter width CW=$clog2(MAX_SLICE_WIDTH)
// PORTS   (BW = PIXS_PER_BEAT*NBR_COMP*BPC)
//  clk_core        in   1                 core clock, all logic
//  rst_n           in   1                 synchronous active-low reset
//  flush           in   1                 synchronous clear of FIFOs/counters/FSM, same effect as reset
//  slices_per_line in   $clog2(NBR_SLICES+1) active slices, 1..NBR_SLICES, static while not IDLE
//  slice_width     in   CW                pixels per slice line, static while not IDLE
//  frame_height    in   16                lines per frame, static while not IDLE
//  eoc_valid_pixs  in   $clog2(PIXS_PER_BEAT+1) valid pixels in last beat of each chunk; 0 = all
//  in_data         in   NBR_SLICES*BW     slice s beat at [s*BW+:BW]; pixel p comp c at (p*NBR_COMP+c)*BPC
//  in_valid        in   NBR_SLICES        per-slice beat valid
//  in_sof          in   NBR_SLICES        per-slice first beat of frame, qualified by in_valid
//  in_ready        out  NBR_SLICES        per-slice FIFO not full
//  out_data        out  BW                interleaved beat
//  out_valid       out  1                 out_data valid
//  out_mask        out  PIXS_PER_BEAT     per-pixel valid, bit p = pixel p
//  out_ready       in   1                 downstream accept
//  out_sof/eol/eof out  1 each            frame start / line end / frame end, qualified by out_valid
//  overflow_err    out  NBR_SLICES        sticky: in_valid while in_ready=0
// BEHAVIOUR
//  Reset/flush: all FIFOs empty, FSM=IDLE, sel=0, counters 0; all outputs 0 except in_ready=all 1s.
//  FIFOs: each entry holds {sof,data}, BW+1 bits. Write on in_valid&in_ready.
//   in_ready = (count!=FIFO_DEPTH) from the registered count; a full FIFO with a same-cycle pop still refuses the write.
//   No write-side sof check; a sof beat with old data ahead of it is queued behind that data.
//  Beats per chunk: NB = ceil(slice_width/PIXS_PER_BEAT), computed as (slice_width+PIXS_PER_BEAT-1)>>log2(PIXS_PER_BEAT).
//  Output stage: one register. It loads when (~out_valid|out_ready) and FIFO[sel] is non-empty. Pop and load happen in the same cycle.
//   Latency from FIFO head to out_valid is 1 cycle. out_data/flags stay stable while out_valid&~out_ready.
//   If FIFO[sel] is empty, out_valid drops after the current beat is accepted (bubble). No slice skipping.
//  FSM: IDLE -> RUN when the FIFO[0] head has sof=1. Head beats with sof=0 in IDLE are popped and discarded.
//   RUN -> IDLE on the accepted beat that carries out_eof. Any sof head in RUN is treated as data; no resync.
//  Counters (advance on load): beat_cnt 0..NB-1. At NB-1 it wraps; sel advances and wraps at slices_per_line-1.
//   line_cnt 16b increments when sel wraps.
//  Flags on loaded beat: out_sof when first beat of slice 0 in a frame.
//   out_eol when beat_cnt==NB-1 & sel==slices_per_line-1. out_eof when out_eol & line_cnt==frame_height-1.
//  out_mask: all ones except the last beat of each chunk, which = (1<<eoc_valid_pixs)-1 if eoc_valid_pixs!=0.
//  slices_per_line=1: sel stays 0. NB=1: every beat is first+last of chunk; mask rule applies.
//  overflow_err[s] is set on in_valid[s]&~in_ready[s] and cleared only by reset/flush.
//  Reset or flush mid-frame: in-flight data is dropped, out_valid=0 next cycle, and the block waits for a new sof.
// TESTING
//  T1 NBR_SLICES=2, width=8, height=2, eoc=0, out_ready=1: out order S0L0,S1L0,S0L1,S1L1, 2 beats each.
//     out_sof on beat0; out_eol on beats 3 and 7; out_eof on beat 7.
//  T2 width=10, eoc=2, PIXS_PER_BEAT=4: NB=3; third beat of every chunk has out_mask=4'b0011, others 4'b1111.
//  T3 out_ready toggles 1,0,0,1 at random: out_data/flags stay stable while stalled; no beat lost or duplicated vs. scoreboard.
//  T4 hold out_ready=0 until FIFO[1] reaches 64 entries: in_ready[1]=0. Force in_valid[1]=1: overflow_err[1]=1 and stays set.
//  T5 slice 1 starved for 10 cycles mid-line: out_valid=0 for those cycles; slice 0 data not emitted early.
//  T6 flush asserted on the beat after out_sof: next cycle out_valid=0 and in_ready=all 1s.
//     The next frame's sof is output correctly with line_cnt=0.

Source files
------------

// File: rtl/slice_interleaver_if.sv
// Stream bundle between the slice decoders, the interleaver and the output formatter.
// The slave modport is the interleaver's view; master is the surrounding environment.
interface slice_interleaver_if #(
  parameter int unsigned NBR_SLICES    = 4,
  parameter int unsigned PIXS_PER_BEAT = 4,
  parameter int unsigned BW            = 168
);
  logic [NBR_SLICES*BW-1:0] in_data;
  logic [NBR_SLICES-1:0]    in_valid;
  logic [NBR_SLICES-1:0]    in_sof;
  logic [NBR_SLICES-1:0]    in_ready;
  logic [BW-1:0]            out_data;
  logic                     out_valid;
  logic [PIXS_PER_BEAT-1:0] out_mask;
  logic                     out_ready;
  logic                     out_sof;
  logic                     out_eol;
  logic                     out_eof;

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, out_data, out_valid, out_mask, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, out_data, out_valid, out_mask, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/slice_interleaver.sv
// Buffers per-slice pixel beats in FIFOs and interleaves one chunk (slice line) per slice,
// round-robin, into a raster stream with frame/line flags and a per-pixel valid mask.
module slice_interleaver #(
  parameter int unsigned NBR_SLICES      = 4,
  parameter int unsigned PIXS_PER_BEAT   = 4,
  parameter int unsigned NBR_COMP        = 3,
  parameter int unsigned BPC             = 14,
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned MAX_SLICE_WIDTH = 2560,
  localparam int unsigned BW    = PIXS_PER_BEAT * NBR_COMP * BPC,
  localparam int unsigned CW    = $clog2(MAX_SLICE_WIDTH),
  localparam int unsigned SW    = $clog2(NBR_SLICES + 1),
  localparam int unsigned PW    = $clog2(PIXS_PER_BEAT + 1),
  localparam int unsigned AW    = $clog2(FIFO_DEPTH),
  localparam int unsigned LOG2P = $clog2(PIXS_PER_BEAT)
) (
  input  logic                  clk_core,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [SW-1:0]         slices_per_line,
  input  logic [CW-1:0]         slice_width,
  input  logic [15:0]           frame_height,
  input  logic [PW-1:0]         eoc_valid_pixs,
  slice_interleaver_if.slave    bus,
  output logic [NBR_SLICES-1:0] overflow_err
);

  typedef enum logic {StIdle, StRun} state_e;

  logic clr;
  assign clr = ~rst_n | flush;

  // ---------------------------------------------------------------------------
  // Per-slice FIFOs
  // ---------------------------------------------------------------------------
  logic [BW:0]           head [NBR_SLICES];
  logic [NBR_SLICES-1:0] not_empty;
  logic [NBR_SLICES-1:0] pop;
  logic [NBR_SLICES-1:0] in_ready_w;
  logic [NBR_SLICES-1:0] ovf_w;

  for (genvar s = 0; s < NBR_SLICES; s++) begin : g_fifo
    logic [BW:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          push;

    // Ready comes from the registered count only, so a full FIFO refuses even with a pop pending.
    assign in_ready_w[s] = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push          = bus.in_valid[s] & in_ready_w[s];
    assign not_empty[s]  = (count_q != '0);
    assign head[s]       = mem[rd_ptr_q];
    assign ovf_w[s]      = ovf_q;

    always_ff @(posedge clk_core) begin
      if (push) begin
        mem[wr_ptr_q] <= {bus.in_sof[s], bus.in_data[s*BW +: BW]};
      end
    end

    always_ff @(posedge clk_core) begin
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop[s]) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop[s]);
        if (bus.in_valid[s] & ~in_ready_w[s]) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = in_ready_w;
  assign overflow_err = ovf_w;

  // ---------------------------------------------------------------------------
  // Selected-slice head and chunk geometry
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [SW-1:0]       sel_q;
  logic [CW:0]         beat_cnt_q;
  logic [15:0]         line_cnt_q;
  logic [CW:0]         nb;
  logic [BW:0]         sel_head;
  logic                sel_avail;

  always_comb begin
    sel_head  = '0;
    sel_avail = 1'b0;
    for (int s = 0; s < NBR_SLICES; s++) begin
      if (sel_q == SW'(s)) begin
        sel_head  = head[s];
        sel_avail = not_empty[s];
      end
    end
  end

  assign nb = ({1'b0, slice_width} + (CW+1)'(PIXS_PER_BEAT - 1)) >> LOG2P;

  logic                     last_beat;
  logic                     last_sel;
  logic                     first_beat;
  logic                     eol_d;
  logic                     eof_d;
  logic [PIXS_PER_BEAT-1:0] mask_d;

  always_comb begin
    last_beat  = (beat_cnt_q == nb - 1'b1);
    last_sel   = (sel_q == slices_per_line - 1'b1);
    first_beat = (beat_cnt_q == '0) & (sel_q == '0) & (line_cnt_q == '0);
    eol_d      = last_beat & last_sel;
    eof_d      = eol_d & (line_cnt_q == frame_height - 16'd1);
    for (int p = 0; p < PIXS_PER_BEAT; p++) begin
      mask_d[p] = ~last_beat | (eoc_valid_pixs == '0) | (PW'(p) < eoc_valid_pixs);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  logic out_valid_q;
  logic out_eof_q;
  logic slot_free;
  logic load;
  logic discard;

  always_ff @(posedge clk_core) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (load) state_d = StRun;
      StRun:  if (out_valid_q & bus.out_ready & out_eof_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    slot_free = ~out_valid_q | bus.out_ready;
    load      = 1'b0;
    discard   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_avail) begin
          load    = sel_head[BW] & slot_free;
          discard = ~sel_head[BW];
        end
      end
      // Hold off the next frame until the eof beat leaves, so its sof is seen from idle.
      StRun: load = sel_avail & slot_free & ~(out_valid_q & out_eof_q);
      default: ;
    endcase
    pop = '0;
    for (int s = 0; s < NBR_SLICES; s++) begin
      if ((load | discard) && (sel_q == SW'(s))) begin
        pop[s] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Position counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_core) begin
    if (clr) begin
      beat_cnt_q <= '0;
      sel_q      <= '0;
      line_cnt_q <= '0;
    end else if (load) begin
      if (last_beat) begin
        beat_cnt_q <= '0;
        if (last_sel) begin
          sel_q      <= '0;
          line_cnt_q <= eof_d ? 16'd0 : line_cnt_q + 16'd1;
        end else begin
          sel_q <= sel_q + 1'b1;
        end
      end else begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [BW-1:0]            out_data_q;
  logic [PIXS_PER_BEAT-1:0] out_mask_q;
  logic                     out_sof_q;
  logic                     out_eol_q;

  always_ff @(posedge clk_core) begin
    if (clr) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_head[BW-1:0];
      out_mask_q  <= mask_d;
      out_sof_q   <= first_beat;
      out_eol_q   <= eol_d;
      out_eof_q   <= eof_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_eof   = out_eof_q;

endmodule
